// File: rtl/alsu_result_buffer.sv
// ALSU result capture FIFO with show-ahead drain port,
// saturating error/drop counters and sticky overflow flag.
module alsu_result_buffer #(
   parameter int DEPTH = 8,
   parameter int OUT_W = 6,
   parameter int LED_W = 16,
   parameter int CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic signed [OUT_W-1:0]    out,
   input  logic [LED_W-1:0]           leds,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic signed [OUT_W-1:0]    m_data,
   output logic                       m_err,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic [CNT_W-1:0]           err_cnt,
   output logic [CNT_W-1:0]           drop_cnt,
   output logic                       overflow,
   input  logic                       clr_stats
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]      CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]      CNT_MAX = (AW+1)'(DEPTH);
   localparam logic [AW-1:0]    PTR_ONE = AW'(1);
   localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

   logic [OUT_W:0]  mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            err_in;
   logic            pop;
   logic            acc;
   logic            drop;
   logic [OUT_W:0]  head;

   assign err_in  = |leds;
   assign empty   = (count == '0);
   assign full    = (count == CNT_MAX);
   assign m_valid = !empty;
   assign pop     = m_valid & m_ready;
   // A pop in the same cycle frees the slot this push lands in
   assign acc     = in_valid & (!full | pop);
   assign drop    = in_valid & !acc;

   assign head   = mem[rd_ptr];
   assign m_data = empty ? '0 : head[OUT_W-1:0];
   assign m_err  = empty ? 1'b0 : head[OUT_W];

   always_ff @(posedge clk) begin
      if (acc)
         mem[wr_ptr] <= {err_in, out};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (acc)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         unique case ({acc, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_cnt  <= '0;
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else if (clr_stats) begin
         err_cnt  <= '0;
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         if (acc && err_in && err_cnt != '1)
            err_cnt <= err_cnt + STAT_ONE;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1)
               drop_cnt <= drop_cnt + STAT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_alsu_result_buffer.sv
// Randomised and directed bench for alsu_result_buffer
// against a queue-based reference model.
module tb_alsu_result_buffer;

   localparam int DEPTH = 8;
   localparam int OUT_W = 6;
   localparam int LED_W = 16;
   localparam int CNT_W = 8;
   localparam int SAT = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid = 1'b0;
   logic signed [OUT_W-1:0] out_d = '0;
   logic [LED_W-1:0] leds = '0;
   logic m_ready = 1'b0;
   logic clr_stats = 1'b0;
   logic m_valid;
   logic signed [OUT_W-1:0] m_data;
   logic m_err;
   logic [3:0] count;
   logic full;
   logic empty;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] drop_cnt;
   logic overflow;

   int n_run = 0;
   int n_fail = 0;

   // model state: entries are {err, out}
   logic [OUT_W:0] q[$];
   int m_errc = 0;
   int m_drop = 0;
   bit m_ovf = 0;

   alsu_result_buffer #(
      .DEPTH(DEPTH), .OUT_W(OUT_W), .LED_W(LED_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .out(out_d),
      .leds(leds), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_err(m_err), .count(count), .full(full),
      .empty(empty), .err_cnt(err_cnt), .drop_cnt(drop_cnt),
      .overflow(overflow), .clr_stats(clr_stats)
   );

   always #5 clk = ~clk;

   task automatic model_edge();
      bit pop, acc, e;
      if (!rst) begin
         q.delete();
         m_errc = 0;
         m_drop = 0;
         m_ovf = 0;
         return;
      end
      e = (leds != 0);
      pop = (q.size() > 0) && m_ready;
      acc = in_valid && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back({e, out_d});
      if (clr_stats) begin
         m_errc = 0;
         m_drop = 0;
         m_ovf = 0;
      end else begin
         if (acc && e && m_errc < SAT) m_errc++;
         if (in_valid && !acc) begin
            m_ovf = 1;
            if (m_drop < SAT) m_drop++;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      in_valid = 0;
      m_ready = 0;
      clr_stats = 0;
      leds = '0;
   endtask

   task automatic clear_stats();
      idle();
      clr_stats = 1;
      tick();
      clr_stats = 0;
   endtask

   task automatic test_reset();
      rst = 0;
      in_valid = 1;
      m_ready = 1;
      for (int i = 0; i < 4; i++) begin
         out_d = OUT_W'($urandom);
         leds = LED_W'($urandom);
         tick();
      end
      n_run++;
      if ({m_valid, m_data, m_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_out: got v=%0b d=%0d e=%0b want 0",
                  m_valid, m_data, m_err);
      end
      n_run++;
      if ({empty, full, count} !== {1'b1, 1'b0, 4'd0}) begin
         n_fail++;
         $display("FAIL reset_flags: got e=%0b f=%0b c=%0d want 1 0 0",
                  empty, full, count);
      end
      n_run++;
      if ({err_cnt, drop_cnt, overflow} !== '0) begin
         n_fail++;
         $display("FAIL reset_stats: got %0d %0d %0b want 0",
                  err_cnt, drop_cnt, overflow);
      end
      idle();
      rst = 1;
   endtask

   task automatic test_order();
      logic signed [OUT_W-1:0] vals[3];
      vals = '{-6'sd32, 6'sd31, 6'sd5};
      idle();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1;
         out_d = vals[i];
         tick();
      end
      idle();
      m_ready = 1;
      for (int i = 0; i < 3; i++) begin
         n_run++;
         if (m_data !== vals[i] || m_err !== 1'b0 || !m_valid) begin
            n_fail++;
            $display("FAIL order_%0d: got d=%0d e=%0b want d=%0d e=0",
                     i, m_data, m_err, vals[i]);
         end
         tick();
      end
      n_run++;
      if (empty !== 1'b1 || m_data !== '0) begin
         n_fail++;
         $display("FAIL order_empty: got e=%0b d=%0d want 1 0",
                  empty, m_data);
      end
      idle();
   endtask

   task automatic test_overflow();
      logic [OUT_W-1:0] vals[10];
      clear_stats();
      for (int i = 0; i < 10; i++) begin
         vals[i] = OUT_W'($urandom);
         in_valid = 1;
         out_d = vals[i];
         tick();
      end
      idle();
      n_run++;
      if (full !== 1'b1 || count !== 4'd8) begin
         n_fail++;
         $display("FAIL ovf_full: got f=%0b c=%0d want 1 8", full, count);
      end
      n_run++;
      if (drop_cnt !== 8'd2 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_drop: got d=%0d o=%0b want 2 1",
                  drop_cnt, overflow);
      end
      m_ready = 1;
      for (int i = 0; i < 8; i++) begin
         n_run++;
         if (m_data !== vals[i]) begin
            n_fail++;
            $display("FAIL ovf_drain_%0d: got %0d want %0d",
                     i, m_data, $signed(vals[i]));
         end
         tick();
      end
      idle();
   endtask

   task automatic test_full_pushpop();
      clear_stats();
      for (int i = 0; i < DEPTH; i++) begin
         in_valid = 1;
         out_d = OUT_W'($urandom);
         tick();
      end
      for (int i = 0; i < 20; i++) begin
         in_valid = 1;
         m_ready = 1;
         out_d = (i == 19) ? 6'sd7 : OUT_W'($urandom);
         tick();
         n_run++;
         if (count !== 4'd8 || drop_cnt !== 8'd0 ||
             m_data !== q[0][OUT_W-1:0]) begin
            n_fail++;
            $display("FAIL fullpp_%0d: got c=%0d dr=%0d d=%0d want 8 0 %0d",
                     i, count, drop_cnt, m_data, $signed(q[0][OUT_W-1:0]));
         end
      end
      idle();
      m_ready = 1;
      for (int i = 0; i < DEPTH - 1; i++) tick();
      n_run++;
      if (m_data !== 6'sd7 || count !== 4'd1) begin
         n_fail++;
         $display("FAIL fullpp_last: got d=%0d c=%0d want 7 1",
                  m_data, count);
      end
      tick();
      idle();
   endtask

   task automatic test_err_clr();
      bit exp_err[5];
      exp_err = '{1, 1, 1, 0, 1};
      clear_stats();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1;
         out_d = OUT_W'($urandom);
         leds = (i < 3) ? 16'hFFFF : 16'h0000;
         tick();
      end
      n_run++;
      if (err_cnt !== 8'd3) begin
         n_fail++;
         $display("FAIL err_cnt3: got %0d want 3", err_cnt);
      end
      leds = 16'h0010;
      clr_stats = 1;
      tick();
      idle();
      n_run++;
      if (err_cnt !== 8'd0 || count !== 4'd5) begin
         n_fail++;
         $display("FAIL err_clr: got e=%0d c=%0d want 0 5", err_cnt, count);
      end
      m_ready = 1;
      for (int i = 0; i < 5; i++) begin
         n_run++;
         if (m_err !== exp_err[i]) begin
            n_fail++;
            $display("FAIL err_tag_%0d: got %0b want %0b",
                     i, m_err, exp_err[i]);
         end
         tick();
      end
      idle();
   endtask

   task automatic test_saturate();
      clear_stats();
      in_valid = 1;
      m_ready = 1;
      leds = 16'h0001;
      for (int i = 0; i < 260; i++) begin
         out_d = OUT_W'($urandom);
         tick();
      end
      n_run++;
      if (err_cnt !== 8'hFF) begin
         n_fail++;
         $display("FAIL err_sat: got %0d want 255", err_cnt);
      end
      m_ready = 0;
      for (int i = 0; i < 270; i++) tick();
      n_run++;
      if (drop_cnt !== 8'hFF || err_cnt !== 8'hFF) begin
         n_fail++;
         $display("FAIL drop_sat: got d=%0d e=%0d want 255 255",
                  drop_cnt, err_cnt);
      end
      idle();
      m_ready = 1;
      for (int i = 0; i < DEPTH; i++) tick();
      idle();
   endtask

   task automatic test_reset_mid();
      clear_stats();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1;
         out_d = OUT_W'($urandom);
         leds = 16'h8000;
         tick();
      end
      idle();
      #2;
      rst = 0;
      #1;
      q.delete();
      m_errc = 0;
      m_drop = 0;
      m_ovf = 0;
      n_run++;
      if (m_valid !== 1'b0 || count !== 4'd0 || err_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL mid_rst: got v=%0b c=%0d e=%0d want 0 0 0",
                  m_valid, count, err_cnt);
      end
      in_valid = 1;
      tick();
      rst = 1;
      out_d = -6'sd3;
      tick();
      idle();
      tick();
      n_run++;
      if (count !== 4'd1 || m_data !== -6'sd3) begin
         n_fail++;
         $display("FAIL mid_after: got c=%0d d=%0d want 1 -3", count, m_data);
      end
      m_ready = 1;
      tick();
      idle();
   endtask

   task automatic test_random();
      logic [OUT_W:0] hd;
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         m_ready = ($urandom_range(0, 2) == 0);
         clr_stats = ($urandom_range(0, 40) == 0);
         out_d = OUT_W'($urandom);
         leds = ($urandom_range(0, 2) == 0) ? LED_W'($urandom) : '0;
         tick();
         hd = (q.size() > 0) ? q[0] : '0;
         n_run++;
         if (m_valid !== (q.size() > 0) || m_data !== hd[OUT_W-1:0] ||
             m_err !== hd[OUT_W] || count !== 4'(q.size()) ||
             full !== (q.size() == DEPTH) || empty !== (q.size() == 0) ||
             err_cnt !== CNT_W'(m_errc) || drop_cnt !== CNT_W'(m_drop) ||
             overflow !== m_ovf) begin
            n_fail++;
            $display("FAIL rand_%0d: got v%0b d%0d e%0b c%0d ec%0d dc%0d o%0b want v%0b d%0d e%0b c%0d ec%0d dc%0d o%0b",
                     i, m_valid, m_data, m_err, count, err_cnt, drop_cnt,
                     overflow, q.size() > 0, $signed(hd[OUT_W-1:0]),
                     hd[OUT_W], q.size(), m_errc, m_drop, m_ovf);
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_order();
      test_overflow();
      test_full_pushpop();
      test_err_clr();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/alsu_result_buffer.md
# alsu_result_buffer

Downstream capture stage for the ALSU. Samples the signed `out` result and the `leds` error indication whenever the upstream driver marks a result valid, and stores each one as a tagged entry in a small FIFO. Entries are drained through a valid/ready port by the checker or host side. The block also keeps saturating error and drop counters plus a sticky overflow flag for scoreboard and debug use.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥ 2.
- `OUT_W`, 6: width of the ALSU `out` result (signed).
- `LED_W`, 16: width of the ALSU `leds` bus.
- `CNT_W`, 8: width of the error and drop counters.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  the ALSU `out`/`leds` pair is a new result this cycle.
- `out`  in  OUT_W  signed ALSU result.
- `leds`  in  LED_W  ALSU LED bus; any nonzero bit marks the result as an error.
- `m_valid`  out  1  head entry available.
- `m_ready`  in  1  consumer accepts the head entry.
- `m_data`  out  OUT_W  signed head result.
- `m_err`  out  1  error tag of the head entry.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `err_cnt`  out  CNT_W  accepted entries with the error tag set (saturating).
- `drop_cnt`  out  CNT_W  results dropped on overflow (saturating).
- `overflow`  out  1  sticky: at least one drop since reset or clear.
- `clr_stats`  in  1  synchronous clear of `err_cnt`, `drop_cnt` and `overflow`.

## Operation
- Entry format: {err, out}, where err = |leds.
- Push attempt: `in_valid` = 1.
- Pop: `m_valid` & `m_ready`.
- A push is accepted when count < DEPTH, or when a pop happens in the same cycle.
- On acceptance:
  - write the entry at wr_ptr;
  - wr_ptr wraps from DEPTH-1 to 0;
  - if err = 1, increment `err_cnt`.
- A push that is not accepted is a drop:
  - the entry is discarded and FIFO contents are unchanged;
  - `drop_cnt` increments;
  - `overflow` is set to 1.
- On pop, rd_ptr advances with the same wrap rule.
- count update:
  - +1 on push only;
  - −1 on pop only;
  - unchanged on simultaneous push and pop, including at full.
- Show-ahead output:
  - `m_valid` = !empty;
  - `m_data`/`m_err` = entry at rd_ptr;
  - both are forced to 0 when empty.
- `m_ready` while empty: no effect.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- `clr_stats`:
  - zeroes the counters and `overflow`;
  - takes priority over a same-cycle increment, so the increment is lost;
  - does not affect FIFO contents.
- `out` is stored bit-exact. No sign extension or arithmetic is applied.

## Timing
- Reset (`rst` = 0, asynchronous assert):
  - pointers = 0, count = 0, `empty` = 1, `full` = 0;
  - `m_valid` = 0, `m_data` = 0, `m_err` = 0;
  - `err_cnt` = 0, `drop_cnt` = 0, `overflow` = 0;
  - RAM contents are don't-care.
- Reset release is sampled synchronously. The first push is accepted on the first rising edge with `rst` = 1.
- Reset mid-operation: all entries are lost immediately, and outputs take their reset values within the same cycle.
- Latency: a result pushed at edge N appears at `m_valid`/`m_data` after edge N. There is no same-cycle bypass from input to output when empty.
- `full`, `empty` and `count` are registered and reflect the state after the last edge.
- `in_valid` is ignored while `rst` = 0.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset check: hold `rst` = 0 with `in_valid` = 1 and random data → all outputs at reset values, `empty` = 1, count = 0.
- Ordered store and drain: push `out` = −32, 31, 5 with `leds` = 0, `m_ready` = 0; then raise `m_ready` → `m_data` reads −32, 31, 5 on consecutive cycles, `m_err` = 0 throughout, `empty` = 1 afterwards.
- Overflow: push 10 results into the DEPTH = 8 FIFO with `m_ready` = 0 → `full` = 1, count = 8, `drop_cnt` = 2, `overflow` = 1; drain returns the first 8 results in order.
- Full with simultaneous push and pop: at full, push 7 while popping → no drop, count stays 8, 7 emerges last; run 20 cycles of this to exercise pointer wrap.
- Error tagging and clear: push 3 results with `leds` = 16'hFFFF, then 1 with `leds` = 0 → `err_cnt` = 3, `m_err` sequence 1,1,1,0. Then `clr_stats` in the same cycle as an error push → `err_cnt` = 0, entry still stored with `m_err` = 1.
- Reset mid-stream: with 5 entries stored, pulse `rst` low mid-cycle → `m_valid` drops asynchronously, count = 0, counters = 0; after release, the next push yields a single entry.
